serial_flow_unit: RTL and testbench

Parametrised successor to the two-line serial flow FSM (ITC99 b01 family). Two serial bit streams (line1, line2) arrive LSB-first, one bit per accepted cycle, framed into words of WORD_W bits. Per word the block performs a selectable operation (add, subtract, compare), returns the serial result bit-by-bit and flags overflow/borrow or the relation at word end. Sits between the pattern-driven stimulus interface and the checker logic in the benchmark test harness.

---
 rtl/sfu_pkg.sv | 13 +
 rtl/serial_bit_alu.sv | 33 +++
 rtl/serial_flow_unit.sv | 153 +++++++++++++++
 tb/tb_serial_flow_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_pkg.sv
// Shared encodings for the serial flow unit: operation modes and FSM states.
package sfu_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_CMP = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/serial_bit_alu.sv
// Combinational per-bit core: one full-adder step for add/sub, one tracker step for compare.
module serial_bit_alu
  import sfu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       carry_i,
  input  logic [1:0] mode_i,
  input  logic       eq_t_i,
  input  logic       gt_t_i,
  output logic       res_o,
  output logic       carry_o,
  output logic       eq_t_o,
  output logic       gt_t_o
);

  logic b_eff;

  always_comb begin
    // NOTE: every output is assigned up front so no path through the block can infer a latch.
    b_eff   = (mode_i == MODE_SUB) ? ~b_i : b_i;
    res_o   = a_i ^ b_eff ^ carry_i;
    carry_o = (a_i & b_eff) | (a_i & carry_i) | (b_eff & carry_i);
    eq_t_o  = eq_t_i & (a_i ~^ b_i);
    // LSB-first: a later (more significant) differing bit overrides earlier ones.
    gt_t_o  = (a_i != b_i) ? a_i : gt_t_i;
    if (mode_i == MODE_CMP) begin
      res_o   = 1'b0;
      carry_o = carry_i;
    end
  end

endmodule

// File: rtl/serial_flow_unit.sv
// Two-line serial add/subtract/compare unit: LSB-first words of WORD_W bits, registered outputs.
module serial_flow_unit
  import sfu_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  input  logic       line1,
  input  logic       line2,
  input  logic [1:0] mode,
  output logic       outp,
  output logic       out_valid,
  output logic       word_done,
  output logic       overflw,
  output logic       eq,
  output logic       gt
);

  localparam int CNT_W = $clog2(WORD_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [1:0]         mode_q, mode_d;
  logic               eq_t_q, eq_t_d, gt_t_q, gt_t_d;
  logic               outp_q, outp_d, out_valid_q, out_valid_d, word_done_q, word_done_d;
  logic               overflw_q, overflw_d, eq_q, eq_d, gt_q, gt_d;

  logic               last_bit;
  logic [1:0]         op_mode;
  logic               carry_in, eq_in, gt_in;
  logic               alu_res, alu_carry, alu_eq, alu_gt;

  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_W'(WORD_W - 1));

  // Bit 0 uses the live mode and fresh initial values; later bits use the latched context.
  assign op_mode  = (state_q == ST_IDLE) ? mode : mode_q;
  assign carry_in = (state_q == ST_IDLE) ? (mode == MODE_SUB) : carry_q;
  assign eq_in    = (state_q == ST_IDLE) ? 1'b1 : eq_t_q;
  assign gt_in    = (state_q == ST_IDLE) ? 1'b0 : gt_t_q;

  serial_bit_alu u_alu (
    .a_i     (line1),
    .b_i     (line2),
    .carry_i (carry_in),
    .mode_i  (op_mode),
    .eq_t_i  (eq_in),
    .gt_t_i  (gt_in),
    .res_o   (alu_res),
    .carry_o (alu_carry),
    .eq_t_o  (alu_eq),
    .gt_t_o  (alu_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so all registers update together.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (in_valid) begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  state_d = last_bit ? ST_IDLE : ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    eq_t_d      = eq_t_q;
    gt_t_d      = gt_t_q;
    outp_d      = 1'b0;
    out_valid_d = 1'b0;
    word_done_d = 1'b0;
    overflw_d   = overflw_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    if (clr) begin
      cnt_d     = '0;
      carry_d   = 1'b0;
      eq_t_d    = 1'b0;
      gt_t_d    = 1'b0;
      overflw_d = 1'b0;
      eq_d      = 1'b0;
      gt_d      = 1'b0;
    end else if (in_valid) begin
      mode_d      = op_mode;
      cnt_d       = last_bit ? '0 : cnt_q + 1'b1;
      carry_d     = alu_carry;
      eq_t_d      = alu_eq;
      gt_t_d      = alu_gt;
      outp_d      = alu_res;
      out_valid_d = 1'b1;
      if (last_bit) begin
        word_done_d = 1'b1;
        overflw_d   = (op_mode == MODE_SUB) ? ~alu_carry :
                      (op_mode == MODE_CMP) ? 1'b0 : alu_carry;
        eq_d        = (op_mode == MODE_CMP) & alu_eq;
        gt_d        = (op_mode == MODE_CMP) & alu_gt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= MODE_ADD;
      eq_t_q      <= 1'b0;
      gt_t_q      <= 1'b0;
      outp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      overflw_q   <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      eq_t_q      <= eq_t_d;
      gt_t_q      <= gt_t_d;
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
      word_done_q <= word_done_d;
      overflw_q   <= overflw_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign outp      = outp_q;
  assign out_valid = out_valid_q;
  assign word_done = word_done_q;
  assign overflw   = overflw_q;
  assign eq        = eq_q;
  assign gt        = gt_q;

endmodule

// File: tb/tb_serial_flow_unit.sv
// Self-checking bench for serial_flow_unit (WORD_W=4): word-level arithmetic model plus directed checks.
module tb_serial_flow_unit;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       line1 = 1'b0;
  logic       line2 = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       outp, out_valid, word_done, overflw, eq, gt;

  int n_checks = 0;
  int n_errors = 0;

  serial_flow_unit #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .line1     (line1),
    .line2     (line2),
    .mode      (mode),
    .outp      (outp),
    .out_valid (out_valid),
    .word_done (word_done),
    .overflw   (overflw),
    .eq        (eq),
    .gt        (gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Word-level model: operands are accumulated, and each result bit is taken from plain
  // integer add/subtract of the operand bits received so far.
  int   m_idx = 0, m_a = 0, m_b = 0, m_mode = 0;
  logic e_outp = 0, e_ov = 0, e_wd = 0, e_of = 0, e_eq = 0, e_gt = 0;

  always @(posedge clk or posedge rst) begin
    int k, md, a, b, r, mask;
    if (rst) begin
      m_idx <= 0; m_a <= 0; m_b <= 0; m_mode <= 0;
      e_outp <= 0; e_ov <= 0; e_wd <= 0; e_of <= 0; e_eq <= 0; e_gt <= 0;
    end else if (clr) begin
      m_idx <= 0;
      e_outp <= 0; e_ov <= 0; e_wd <= 0; e_of <= 0; e_eq <= 0; e_gt <= 0;
    end else if (in_valid) begin
      k    = m_idx;
      md   = (k == 0) ? int'(mode) : m_mode;
      a    = ((k == 0) ? 0 : m_a) | (int'(line1) << k);
      b    = ((k == 0) ? 0 : m_b) | (int'(line2) << k);
      mask = (1 << (k + 1)) - 1;
      case (md)
        1:       r = (a - b) & mask;
        2:       r = 0;
        default: r = (a + b) & mask;
      endcase
      e_outp <= r[k];
      e_ov   <= 1'b1;
      e_wd   <= (k == W - 1);
      if (k == W - 1) begin
        e_of <= (md == 1) ? (a < b) : (md == 2) ? 1'b0 : (((a + b) >> W) & 1) != 0;
        e_eq <= (md == 2) && (a == b);
        e_gt <= (md == 2) && (a > b);
      end
      m_idx  <= (k == W - 1) ? 0 : k + 1;
      m_a    <= a;
      m_b    <= b;
      m_mode <= md;
    end else begin
      e_outp <= 0; e_ov <= 0; e_wd <= 0;
    end
  end

  logic run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      check("outp",      outp,      e_outp);
      check("out_valid", out_valid, e_ov);
      check("word_done", word_done, e_wd);
      check("overflw",   overflw,   e_of);
      check("eq",        eq,        e_eq);
      check("gt",        gt,        e_gt);
    end
  end

  // Collector: shifts in result bits LSB-first and snapshots them at word end.
  logic [W-1:0] col_res = '0;
  logic [W-1:0] last_res = '0;
  int           words_done = 0;
  int           valid_cnt = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      col_res = {outp, col_res[W-1:1]};
      valid_cnt++;
      if (word_done) begin
        last_res = col_res;
        words_done++;
      end
    end
  end

  task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] md,
                           input int n, input int stall_after, input int stall_len,
                           input logic [1:0] stall_mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      line1    = a[i];
      line2    = b[i];
      if (i == 0) mode = md;
      if (i == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          in_valid = 1'b0;
          mode     = stall_mode;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic word(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] md, input logic [W-1:0] exp_res, input logic exp_of,
                      input logic exp_eq, input logic exp_gt);
    int wd0;
    wd0 = words_done;
    send_bits(a, b, md, W, -1, 0, 2'b00);
    idle_cycle();
    check({name, "_res"}, last_res, exp_res);
    check({name, "_of"},  overflw, exp_of);
    check({name, "_eq"},  eq, exp_eq);
    check({name, "_gt"},  gt, exp_gt);
    check({name, "_wd"},  words_done - wd0, 1);
  endtask

  initial begin
    int wd0, vc0;
    repeat (2) @(negedge clk);
    check("rst_outp",      outp, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_word_done", word_done, 0);
    check("rst_flags",     {overflw, eq, gt}, 0);
    rst = 1'b0;
    run_cmp = 1'b1;

    word("add_5_3",   4'b0101, 4'b0011, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0);
    word("add_f_1",   4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    word("sub_3_5",   4'b0011, 4'b0101, 2'b01, 4'b1110, 1'b1, 1'b0, 1'b0);
    word("sub_5_3",   4'b0101, 4'b0011, 2'b01, 4'b0010, 1'b0, 1'b0, 1'b0);
    word("cmp_9_9",   4'b1001, 4'b1001, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0);
    word("cmp_8_7",   4'b1000, 4'b0111, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1);
    word("cmp_7_8",   4'b0111, 4'b1000, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
    word("rsv_6_3",   4'b0110, 4'b0011, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0);

    // Stall after bit 1 with mode flipped to compare: result must still be the add.
    wd0 = words_done;
    vc0 = valid_cnt;
    send_bits(4'b0101, 4'b0011, 2'b00, W, 1, 3, 2'b10);
    idle_cycle();
    check("stall_res",    last_res, 4'b1000);
    check("stall_of",     overflw, 0);
    check("stall_valids", valid_cnt - vc0, W);
    check("stall_wd",     words_done - wd0, 1);

    // Back-to-back words with no bubble.
    wd0 = words_done;
    send_bits(4'b1111, 4'b0001, 2'b00, W, -1, 0, 2'b00);
    send_bits(4'b0011, 4'b0101, 2'b01, W, -1, 0, 2'b00);
    idle_cycle();
    check("b2b_res", last_res, 4'b1110);
    check("b2b_of",  overflw, 1);
    check("b2b_wd",  words_done - wd0, 2);

    // Abort with clr colliding with an in_valid bit.
    word("pre_clr", 4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    wd0 = words_done;
    send_bits(4'b0101, 4'b0011, 2'b00, 3, -1, 0, 2'b00);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; line1 = 1'b1; line2 = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    #1;
    check("clr_of",    overflw, 0);
    check("clr_valid", out_valid, 0);
    check("clr_no_wd", words_done - wd0, 0);
    word("post_clr", 4'b0101, 4'b0011, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-word.
    word("pre_rst", 4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    wd0 = words_done;
    send_bits(4'b0101, 4'b0011, 2'b00, 2, -1, 0, 2'b00);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("arst_outp",      outp, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_flags",     {overflw, eq, gt}, 0);
    #1;
    rst = 1'b0;
    check("arst_no_wd", words_done - wd0, 0);
    word("post_rst", 4'b0011, 4'b0101, 2'b01, 4'b1110, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
